// File: rtl/decode_stage.sv
// Decode stage: two-entry skid buffer (main + skid) holding decoded instruction fields.
// Optional DECODE_ILLEGAL_OP_EN adds the illegal / err_sticky opcode check outputs.
module decode_stage #(
    parameter int                   INST_W     = 32,
    parameter int                   OP_W       = 3,
    parameter int                   RA_W       = 5,
    parameter int                   ADDR_W     = 15,
    parameter int                   CNT_W      = 16,
    parameter logic [2**OP_W-1:0]   LEGAL_MASK = 8'b0111_1111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   opcode,
    output logic [RA_W-1:0]   reg_addr_0,
    output logic [RA_W-1:0]   reg_addr_1,
    output logic [RA_W-1:0]   reg_addr_2,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  dec_count
`ifdef DECODE_ILLEGAL_OP_EN
    ,
    output logic              illegal,
    output logic              err_sticky
`endif
);

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [RA_W-1:0]   ra0;
        logic [RA_W-1:0]   ra1;
        logic [RA_W-1:0]   ra2;
        logic [ADDR_W-1:0] addr;
    } fields_t;

    fields_t          in_fields;
    fields_t          main_q, main_d, skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_hs, out_hs;

    // addr deliberately overlaps the low bits of reg_addr_2.
    assign in_fields.opcode = inst[INST_W-1 -: OP_W];
    assign in_fields.ra0    = inst[INST_W-OP_W-1 -: RA_W];
    assign in_fields.ra1    = inst[INST_W-OP_W-RA_W-1 -: RA_W];
    assign in_fields.ra2    = inst[INST_W-OP_W-2*RA_W-1 -: RA_W];
    assign in_fields.addr   = inst[ADDR_W-1:0];

    // flush drops the presented input and blocks the output handshake.
    assign in_hs  = in_valid && in_ready_q && !flush;
    assign out_hs = main_valid_q && out_ready && !flush;

    // NOTE: every _d gets a default first so this block can never infer a latch.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_d       = '0;
            skid_valid_d = 1'b0;
            skid_d       = '0;
        end else if (out_hs) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
                skid_d       = '0;
            end else if (in_hs) begin
                main_d = in_fields;
            end else begin
                main_valid_d = 1'b0;
                main_d       = '0;
            end
        end else if (in_hs) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = in_fields;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = in_fields;
            end
        end
        in_ready_d = !skid_valid_d;
        count_d    = (out_hs && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
    end

    // NOTE: the field registers are reset too, so outputs read 0 whenever out_valid is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            in_ready_q   <= 1'b1;
            count_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments for all sequential state.
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign opcode     = main_q.opcode;
    assign reg_addr_0 = main_q.ra0;
    assign reg_addr_1 = main_q.ra1;
    assign reg_addr_2 = main_q.ra2;
    assign addr       = main_q.addr;
    assign dec_count  = count_q;

`ifdef DECODE_ILLEGAL_OP_EN
    logic err_sticky_q;

    assign illegal = main_valid_q && !LEGAL_MASK[main_q.opcode];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else if (out_hs && illegal) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic vs a queue model.
// Checks the illegal/err_sticky outputs only when DECODE_ILLEGAL_OP_EN is defined.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] inst;

    logic        in_ready, out_valid, in_ready4, out_valid4;
    logic [2:0]  opcode, opcode4;
    logic [4:0]  ra0, ra1, ra2, ra0_4, ra1_4, ra2_4;
    logic [14:0] addr, addr4;
    logic [15:0] dec_count;
    logic [3:0]  dec_count4;
    logic [32:0] obs;
`ifdef DECODE_ILLEGAL_OP_EN
    logic        illegal, err_sticky, illegal4, err_sticky4;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: a FIFO of raw instructions of capacity two, plus handshake totals.
    logic [31:0] q[$];
    int unsigned hs_total;
    bit          sticky_ref;
    logic [7:0]  legal_mask = 8'h7F;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
        .reg_addr_0(ra0), .reg_addr_1(ra1), .reg_addr_2(ra2), .addr(addr),
        .dec_count(dec_count)
`ifdef DECODE_ILLEGAL_OP_EN
        , .illegal(illegal), .err_sticky(err_sticky)
`endif
    );

    decode_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .inst(inst), .out_valid(out_valid4), .out_ready(out_ready), .opcode(opcode4),
        .reg_addr_0(ra0_4), .reg_addr_1(ra1_4), .reg_addr_2(ra2_4), .addr(addr4),
        .dec_count(dec_count4)
`ifdef DECODE_ILLEGAL_OP_EN
        , .illegal(illegal4), .err_sticky(err_sticky4)
`endif
    );

    assign obs = {opcode, ra0, ra1, ra2, addr};

    function automatic logic [32:0] decode_ref(input logic [31:0] w);
        logic [2:0]  op;
        logic [4:0]  r0, r1, r2;
        logic [14:0] a;
        op = 3'(w >> 29);
        r0 = 5'((w >> 24) & 32'h1F);
        r1 = 5'((w >> 19) & 32'h1F);
        r2 = 5'((w >> 14) & 32'h1F);
        a  = 15'(w & 32'h7FFF);
        return {op, r0, r1, r2, a};
    endfunction

    function automatic logic [32:0] exp_fields();
        return (q.size() > 0) ? decode_ref(q[0]) : 33'd0;
    endfunction

    function automatic logic [15:0] exp_count16();
        return (hs_total > 65535) ? 16'hFFFF : 16'(hs_total);
    endfunction

    function automatic logic [3:0] exp_count4();
        return (hs_total > 15) ? 4'hF : 4'(hs_total);
    endfunction

    function automatic bit exp_illegal();
        return (q.size() > 0) && !legal_mask[q[0][31:29]];
    endfunction

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [31:0] w, input logic ordy);
        rst = r; flush = f; in_valid = iv; inst = w; out_ready = ordy;
    endtask

    // Advance the model by one cycle with the currently driven inputs, then clock the DUT.
    task automatic step();
        bit oh, ih;
        if (rst) begin
            q.delete();
            hs_total   = 0;
            sticky_ref = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            oh = (q.size() > 0) && out_ready;
            ih = in_valid && (q.size() < 2);
            if (oh) begin
                if (!legal_mask[q[0][31:29]]) sticky_ref = 1'b1;
                void'(q.pop_front());
                hs_total++;
            end
            if (ih) q.push_back(inst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (obs !== 33'd0) begin errors++; $display("FAIL reset_fields: got %h exp 0", obs); end
        checks++; if (dec_count !== 16'd0) begin errors++; $display("FAIL reset_dec_count: got %0d exp 0", dec_count); end
        checks++; if (dec_count4 !== 4'd0) begin errors++; $display("FAIL reset_dec_count4: got %0d exp 0", dec_count4); end
`ifdef DECODE_ILLEGAL_OP_EN
        checks++; if ({illegal, err_sticky} !== 2'b00) begin errors++; $display("FAIL reset_illegal: got %b exp 00", {illegal, err_sticky}); end
`endif
    endtask

    task automatic test_basic_decode();
        drive(0, 0, 1, 32'h6A5A1234, 1);
        step();
        drive(0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b exp 1", out_valid); end
        checks++; if (opcode !== 3'd3) begin errors++; $display("FAIL basic_opcode: got %0d exp 3", opcode); end
        checks++; if (ra0 !== 5'd10) begin errors++; $display("FAIL basic_ra0: got %0d exp 10", ra0); end
        checks++; if (ra1 !== 5'd11) begin errors++; $display("FAIL basic_ra1: got %0d exp 11", ra1); end
        checks++; if (ra2 !== 5'd8) begin errors++; $display("FAIL basic_ra2: got %0d exp 8", ra2); end
        checks++; if (addr !== 15'h1234) begin errors++; $display("FAIL basic_addr: got %h exp 1234", addr); end
        step();
        checks++; if (dec_count !== 16'd1) begin errors++; $display("FAIL basic_dec_count: got %0d exp 1", dec_count); end
        checks++; if (out_valid !== 1'b0 || obs !== 33'd0) begin errors++; $display("FAIL basic_drain: got valid=%b fields=%h exp 0/0", out_valid, obs); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c;
        a = $urandom; b = $urandom; c = $urandom;
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, a, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c0: got %b exp 1", in_ready); end
        step();
        drive(0, 0, 1, b, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c1: got %b exp 1", in_ready); end
        checks++; if (obs !== decode_ref(a)) begin errors++; $display("FAIL b2b_first_out: got %h exp %h", obs, decode_ref(a)); end
        step();
        drive(0, 0, 1, c, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c2: got %b exp 0", in_ready); end
        checks++; if (obs !== decode_ref(a)) begin errors++; $display("FAIL b2b_hold_c2: got %h exp %h", obs, decode_ref(a)); end
        step();
        drive(0, 0, 0, 0, 1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c3: got %b exp 0", in_ready); end
        checks++; if (obs !== decode_ref(a)) begin errors++; $display("FAIL b2b_out_a: got %h exp %h", obs, decode_ref(a)); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_freed: got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b1 || obs !== decode_ref(b)) begin errors++; $display("FAIL b2b_out_b: got %b/%h exp 1/%h", out_valid, obs, decode_ref(b)); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b exp 0", out_valid); end
        checks++; if (dec_count !== 16'd2) begin errors++; $display("FAIL b2b_dec_count: got %0d exp 2", dec_count); end
    endtask

    task automatic test_flush();
        logic [15:0] dc_before;
        drive(0, 0, 1, $urandom, 0); step();
        drive(0, 0, 1, $urandom, 0); step();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_full: got ready=%b valid=%b exp 0/1", in_ready, out_valid); end
        dc_before = dec_count;
        drive(0, 1, 1, $urandom, 1);
        step();
        drive(0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b exp 1", in_ready); end
        checks++; if (dec_count !== dc_before) begin errors++; $display("FAIL flush_dec_count: got %0d exp %0d", dec_count, dc_before); end
        checks++; if (obs !== 33'd0) begin errors++; $display("FAIL flush_fields: got %h exp 0", obs); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_input: got %b exp 0", out_valid); end
    endtask

    task automatic test_saturate();
        drive(1, 0, 0, 0, 0); step();
        for (int i = 0; i < 21; i++) begin
            drive(0, 0, 1, $urandom & 32'hDFFF_FFFF, 1);
            step();
        end
        drive(0, 0, 0, 0, 1); step(); step();
        checks++; if (dec_count4 !== 4'd15) begin errors++; $display("FAIL sat_dec_count4: got %0d exp 15", dec_count4); end
        checks++; if (dec_count !== 16'd21) begin errors++; $display("FAIL sat_dec_count16: got %0d exp 21", dec_count); end
    endtask

`ifdef DECODE_ILLEGAL_OP_EN
    task automatic test_illegal();
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 32'hE000_0000, 1); step();
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b exp 1", illegal); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL ill_sticky_early: got %b exp 0", err_sticky); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, $urandom & 32'hDFFF_FFFF, 1); step();
            checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_legal_flag: got %b exp 0", illegal); end
            checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL ill_sticky_hold: got %b exp 1", err_sticky); end
        end
        drive(1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL ill_sticky_rst: got %b exp 0", err_sticky); end
    endtask
`endif

    task automatic test_reset_full();
        drive(0, 0, 1, $urandom, 0); step();
        drive(0, 0, 1, $urandom, 0); step();
        drive(0, 0, 1, $urandom, 1); step();
        drive(0, 0, 1, $urandom, 0); step();
        checks++; if (in_ready !== 1'b0 || dec_count === 16'd0) begin errors++; $display("FAIL rstfull_setup: got ready=%b cnt=%0d exp 0/nonzero", in_ready, dec_count); end
        drive(1, 1, 1, $urandom, 1); step();
        drive(0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_in_ready: got %b exp 1", in_ready); end
        checks++; if (dec_count !== 16'd0) begin errors++; $display("FAIL rstfull_dec_count: got %0d exp 0", dec_count); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                  $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid c%0d: got %b exp %b", cyc, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_in_ready c%0d: got %b exp %b", cyc, in_ready, q.size() < 2); end
            checks++; if (obs !== exp_fields()) begin errors++; $display("FAIL rnd_fields c%0d: got %h exp %h", cyc, obs, exp_fields()); end
            checks++; if (dec_count !== exp_count16()) begin errors++; $display("FAIL rnd_dec_count c%0d: got %0d exp %0d", cyc, dec_count, exp_count16()); end
            checks++; if (dec_count4 !== exp_count4()) begin errors++; $display("FAIL rnd_dec_count4 c%0d: got %0d exp %0d", cyc, dec_count4, exp_count4()); end
`ifdef DECODE_ILLEGAL_OP_EN
            checks++; if (illegal !== exp_illegal()) begin errors++; $display("FAIL rnd_illegal c%0d: got %b exp %b", cyc, illegal, exp_illegal()); end
            checks++; if (err_sticky !== sticky_ref) begin errors++; $display("FAIL rnd_sticky c%0d: got %b exp %b", cyc, err_sticky, sticky_ref); end
`endif
            step();
        end
    endtask

    initial begin
        hs_total   = 0;
        sticky_ref = 1'b0;
        drive(1, 0, 0, 0, 0);
        test_reset();
        test_basic_decode();
        test_back_to_back();
        test_flush();
        test_saturate();
`ifdef DECODE_ILLEGAL_OP_EN
        test_illegal();
`endif
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 INST_W, 32, instruction width in bits.
REQ-002 OP_W, 3, opcode field width.
REQ-003 RA_W, 5, register address field width.
REQ-004 ADDR_W, 15, address field width.
REQ-005 CNT_W, 16, decoded-instruction counter width.
REQ-006 LEGAL_MASK, 8'b0111_1111, one bit per opcode value; 1 = legal; width 2**OP_W.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 flush  input  1  discard all buffered instructions.
REQ-010 in_valid  input  1  inst is valid.
REQ-011 in_ready  output  1  stage can accept inst.
REQ-012 inst  input  INST_W  raw instruction.
REQ-013 out_valid  output  1  decoded fields valid.
REQ-014 out_ready  input  1  consumer accepts fields.
REQ-015 opcode  output  OP_W  inst[INST_W-1 -: OP_W].
REQ-016 reg_addr_0  output  RA_W  next RA_W bits below opcode.
REQ-017 reg_addr_1  output  RA_W  next RA_W bits below reg_addr_0.
REQ-018 reg_addr_2  output  RA_W  next RA_W bits below reg_addr_1.
REQ-019 addr  output  ADDR_W  inst[ADDR_W-1:0]; overlapping reg_addr_2 is intended.
REQ-020 dec_count  output  CNT_W  saturating count of output handshakes.
REQ-021 illegal, err_sticky  output  1 each  present only with the macro in REQ-038.

Function
REQ-022 The stage SHALL be a two-entry skid buffer (main + skid) holding decoded fields, not raw instructions.
REQ-023 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-024 in_ready SHALL be a register output, equal to 1 when the skid entry is empty.
REQ-025 An accepted instruction SHALL appear on the outputs in the next cycle when the main entry is empty or is being drained; latency 1 cycle, throughput 1 per cycle.
REQ-026 The skid entry SHALL fill only when an input is accepted while main is valid and out_ready is 0; it SHALL move to main on the next output handshake.
REQ-027 Order SHALL be preserved; no instruction SHALL be dropped or duplicated except by flush or rst.
REQ-028 While out_valid && !out_ready, all field outputs SHALL hold stable.
REQ-029 When both entries are full, in_ready SHALL be 0; a simultaneous output handshake SHALL free one entry, and in_ready SHALL be 1 in the next cycle.
REQ-030 flush SHALL invalidate both entries in the next cycle; an input presented in the flush cycle SHALL be dropped; in_ready SHALL be 1 in the next cycle.
REQ-031 flush SHALL block output handshakes in its cycle; dec_count SHALL be unaffected by flush.
REQ-032 dec_count SHALL increment by 1 per output handshake and saturate at 2**CNT_W-1.
REQ-033 Field outputs SHALL be 0 whenever out_valid is 0.

Reset
REQ-034 On rst: out_valid=0, in_ready=1, both entries invalid, fields=0, dec_count=0.
REQ-035 illegal=0 and err_sticky=0 on rst.
REQ-036 rst SHALL take priority over flush and all handshakes; an in-flight instruction is discarded.
REQ-037 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-038 With DECODE_ILLEGAL_OP_EN defined, illegal SHALL equal ~LEGAL_MASK[opcode] when out_valid is 1, and 0 otherwise.
REQ-039 With the macro, err_sticky SHALL set on any output handshake with illegal=1 and SHALL clear only on rst.
REQ-040 Without the macro, the illegal and err_sticky ports and their logic SHALL be absent.

Verification
REQ-041 Defaults; inst=0x6A5A1234, out_ready=1 -> next cycle opcode=3, reg_addr_0=10, reg_addr_1=11, reg_addr_2=8, addr=0x1234, dec_count=1.
REQ-042 out_ready=0; send 3 back-to-back instructions -> 2 accepted, in_ready=0 from cycle 2; out_ready=1 -> outputs appear in order, 1 per cycle.
REQ-043 Both entries full; assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, dec_count unchanged.
REQ-044 CNT_W=4; perform 20 output handshakes -> dec_count=15.
REQ-045 Macro defined; inst=0xE0000000 -> illegal=1, err_sticky=1 after the handshake and held through later legal instructions until rst.
REQ-046 Assert rst with both entries full -> next cycle out_valid=0, in_ready=1, dec_count=0.
